// File: rtl/count_ctrl.sv
// rtl/count_ctrl.sv - start/stop/clear/lap key controller for the BCD counter chain
// Optional lap path and LAP state built only when COUNT_CTRL_LAP_EN is defined.

module count_ctrl_debounce #(
    parameter int DEBOUNCE_TICKS = 20
) (
    input  logic i_clk,
    input  logic i_rst_n,
    input  logic i_tick,
    input  logic i_key_n,
    output logic o_press
);
    localparam logic [7:0] LP_LAST = 8'(DEBOUNCE_TICKS - 1);

    logic       r_sync1;
    logic       r_sync2;
    logic       r_stable;
    logic       r_stable_d;
    logic [7:0] r_cnt;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_sync1    <= 1'b1;
            r_sync2    <= 1'b1;
            r_stable   <= 1'b1;
            r_stable_d <= 1'b1;
            r_cnt      <= 8'd0;
        end else begin
            r_sync1    <= i_key_n;
            r_sync2    <= r_sync1;
            r_stable_d <= r_stable;
            if (r_sync2 == r_stable) begin
                r_cnt <= 8'd0;
            end else if (i_tick) begin
                // Accept on the tick that brings the count up to DEBOUNCE_TICKS.
                if (r_cnt == LP_LAST) begin
                    r_stable <= r_sync2;
                    r_cnt    <= 8'd0;
                end else begin
                    r_cnt <= r_cnt + 8'd1;
                end
            end
        end
    end

    assign o_press = r_stable_d & ~r_stable;
endmodule

module count_ctrl #(
    parameter int DEBOUNCE_TICKS = 20
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       tick,
    input  logic       key_start_n,
    input  logic       key_clear_n,
    input  logic       key_lap_n,
    output logic       cnt_ena,
    output logic       cnt_clr,
    output logic       freeze,
    output logic [1:0] state
);
    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        RUN   = 2'b01,
        PAUSE = 2'b10,
        LAP   = 2'b11
    } state_t;

    state_t r_state;
    logic   r_cnt_clr;
    logic   w_start_raw;
    logic   w_clear_raw;
    logic   w_lap_raw;
    logic   w_start;
    logic   w_clear;
    logic   w_lap;

    count_ctrl_debounce #(.DEBOUNCE_TICKS(DEBOUNCE_TICKS)) u_db_start (
        .i_clk   (clk),
        .i_rst_n (rst_n),
        .i_tick  (tick),
        .i_key_n (key_start_n),
        .o_press (w_start_raw)
    );

    count_ctrl_debounce #(.DEBOUNCE_TICKS(DEBOUNCE_TICKS)) u_db_clear (
        .i_clk   (clk),
        .i_rst_n (rst_n),
        .i_tick  (tick),
        .i_key_n (key_clear_n),
        .o_press (w_clear_raw)
    );

`ifdef COUNT_CTRL_LAP_EN
    count_ctrl_debounce #(.DEBOUNCE_TICKS(DEBOUNCE_TICKS)) u_db_lap (
        .i_clk   (clk),
        .i_rst_n (rst_n),
        .i_tick  (tick),
        .i_key_n (key_lap_n),
        .o_press (w_lap_raw)
    );
    assign freeze = (r_state == LAP);
`else
    logic w_unused_lap;
    assign w_unused_lap = key_lap_n;
    assign w_lap_raw    = 1'b0;
    assign freeze       = 1'b0;
`endif

    // Same-cycle presses: start beats clear beats lap.
    assign w_start = w_start_raw;
    assign w_clear = w_clear_raw & ~w_start_raw;
    assign w_lap   = w_lap_raw & ~w_start_raw & ~w_clear_raw;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= IDLE;
            r_cnt_clr <= 1'b0;
        end else begin
            r_cnt_clr <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (w_start) begin
                        r_state <= RUN;
                    end else if (w_clear) begin
                        r_cnt_clr <= 1'b1;
                    end
                end
                RUN: begin
                    if (w_start) begin
                        r_state <= PAUSE;
                    end else if (w_lap) begin
                        r_state <= LAP;
                    end
                end
                PAUSE: begin
                    if (w_start) begin
                        r_state <= RUN;
                    end else if (w_clear) begin
                        r_state   <= IDLE;
                        r_cnt_clr <= 1'b1;
                    end
                end
                LAP: begin
`ifdef COUNT_CTRL_LAP_EN
                    if (w_start) begin
                        r_state <= PAUSE;
                    end else if (w_lap) begin
                        r_state <= RUN;
                    end
`else
                    r_state <= RUN;
`endif
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign cnt_ena = tick & ((r_state == RUN) | (r_state == LAP));
    assign cnt_clr = r_cnt_clr;
    assign state   = r_state;
endmodule

// File: doc/count_ctrl.md
# count_ctrl

Start/stop/clear/lap controller for the cascaded BCD counter chain. It debounces the raw push-keys and sequences the first `counter4` stage through `cnt_ena`. It clears the chain through `cnt_clr` and raises `freeze` so the display path holds a lap value. It sits between the board keys and the `freq`-driven counter/display datapath, and uses the divider's tick as both count enable and debounce timebase.

## Interface
- `DEBOUNCE_TICKS`, default 20: number of consecutive `tick` pulses a key level must stay stable before it is accepted (20 ms at 1 kHz); legal range 1..255.
- `clk`  in  1  system clock (50 MHz).
- `rst_n`  in  1  reset; one clock; reset is asynchronous and active-low.
- `tick`  in  1  single-cycle enable pulse from the `freq` divider, synchronous to `clk`.
- `key_start_n`  in  1  raw start/stop key, active low, asynchronous.
- `key_clear_n`  in  1  raw clear key, active low, asynchronous.
- `key_lap_n`  in  1  raw lap key, active low, asynchronous; ignored without `COUNT_CTRL_LAP_EN`.
- `cnt_ena`  out  1  count enable to the first counter stage.
- `cnt_clr`  out  1  one-cycle synchronous clear to all counter stages.
- `freeze`  out  1  display hold request.
- `state`  out  2  FSM state encoding: 00 IDLE, 01 RUN, 10 PAUSE, 11 LAP.

## Operation
- **Per-key synchronisation:** each key passes through a 2-flop synchroniser.
- **Per-key debounce:**
  - An 8-bit counter increments on `tick` while the synced level differs from the stable level.
  - The counter resets to 0 whenever the two levels match.
  - When the counter reaches `DEBOUNCE_TICKS`, the stable level takes the synced level and the counter returns to 0.
- **Press pulse:** a 1→0 transition of a stable level produces a one-cycle press pulse. Releases produce nothing.
- **Simultaneous presses:** when presses land in the same cycle, priority is start > clear > lap. Lower-priority presses in that cycle are dropped.
- **FSM transitions:**
  - IDLE:
    - start → RUN.
    - clear → `cnt_clr` pulse, stay IDLE.
    - lap ignored.
  - RUN:
    - start → PAUSE.
    - lap → LAP.
    - clear ignored.
  - LAP:
    - lap → RUN.
    - start → PAUSE.
    - clear ignored.
  - PAUSE:
    - start → RUN.
    - clear → `cnt_clr` pulse and go to IDLE.
    - lap ignored.
- **Output behaviour:**
  - `cnt_ena` = `tick` AND (state is RUN or LAP). It is combinational from the state register and has no added latency.
  - `freeze` = 1 only in LAP. Counting continues underneath while `freeze` is high.
- **Wrap-around:** wrap of the counter chain is owned by `counter4`; this block never inspects the count.
- **Reset:**
  - Values: state IDLE, `cnt_ena`/`cnt_clr`/`freeze` = 0, synchronisers and stable levels = 1 (released), debounce counters = 0.
  - Reset asserted mid-run aborts immediately with no `cnt_clr` pulse.
  - A key held through reset release is accepted as a press once it has been debounced.

## Timing
- **Raw key edge to press pulse:** 2 clk (synchroniser), then `DEBOUNCE_TICKS` ticks of stable level, then 1 clk (edge detect).
- **State update:** a press pulse in cycle n updates `state` at the edge ending cycle n; the new state is visible in cycle n+1.
- **`cnt_clr`:** registered; high for exactly cycle n+1 after a qualifying clear press in cycle n.
- **`cnt_ena`:**
  - It follows `tick` in the same cycle, gated by the registered state.
  - A `tick` coinciding with a start press from IDLE is not counted. The first counted tick is the next one.
- **Key bounce:** bounce shorter than `DEBOUNCE_TICKS` ticks never produces a pulse.
- **Stuck key:** a key held for any time produces exactly one pulse.

## Configuration
- **`COUNT_CTRL_LAP_EN` defined:** lap debounce path and LAP state are built; behaviour is as above.
- **`COUNT_CTRL_LAP_EN` undefined:**
  - No lap debouncer is built and `key_lap_n` is ignored.
  - `freeze` is tied to 0.
  - LAP (11) is unreachable. If reached by upset, the FSM recovers to RUN on the next cycle.

## Test plan
Common setup: `DEBOUNCE_TICKS`=2, `tick` every 10 clk.
- **Reset values:** drive all outputs through reset → `state`=00, `cnt_ena`=0, `cnt_clr`=0, `freeze`=0; no output change until a key is debounced.
- **Start/stop:** press `key_start_n` for 50 clk → `state`=01 after 2 ticks + 3 clk; `cnt_ena` pulses coincide with `tick`. Second press → `state`=10, `cnt_ena` stays 0.
- **Bounce rejection:** toggle `key_start_n` every 5 clk for 100 clk, then release → no state change. Hold low for 30 clk → exactly one transition.
- **Clear from PAUSE:** from PAUSE, press clear → `cnt_clr` high exactly 1 clk, `state`=00. Clear pressed in RUN → no `cnt_clr`.
- **Simultaneous presses:** start and clear both debounced in the same cycle from IDLE → `state`=01, no `cnt_clr`.
- **Lap (macro defined) and reset:** lap press in RUN → `state`=11, `freeze`=1, `cnt_ena` still pulses. Assert `rst_n` mid-LAP → all outputs 0 at once. Macro undefined → lap press has no effect.
